// File: rtl/ft_fault_monitor.sv
// ft_fault_monitor
//   Debounces a stream of fault codes into a confirmed-fault state machine.
//   State changes are reported as timestamped events through a small
//   first-word-fall-through FIFO. Optional per-channel fix counters.
//
//   Optional feature macro: FT_MON_FIX_CNT_EN
//     defined   -> eight saturating 16-bit fix counters on error_fix_en
//     undefined -> fix_count tied to zero, no counter logic
//
// Ports
//   clk                      : single clock, rising edge
//   rstn                     : synchronous reset, active HIGH despite the name
//   judge_result_smoother    : fault code (0 none, 1..8 channel 0..7, 9..15 uncorrectable)
//   judge_result_smoother_en : code valid strobe
//   error_fix_en             : per-channel corrected-sample strobe
//   fault_channel_mask       : confirmed faulty channels (registered)
//   fault_state              : 0 NORMAL, 1 SUSPECT, 2 CONFIRMED, 3 RECOVER
//   evt_valid/evt_ready      : event handshake, pop on valid && ready
//   evt_data                 : {timestamp[23:0], code[3:0], type[3:0]}
//   evt_overflow             : sticky, an event was dropped on a full FIFO
//   evt_drop_cnt             : dropped events, saturating at 255
//   fix_count                : 8 x 16-bit fix counters, channel 0 in [15:0]
module ft_fault_monitor #(
  parameter int CONFIRM_CNT = 4,
  parameter int CLEAR_CNT   = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [3:0]   judge_result_smoother,
  input  logic         judge_result_smoother_en,
  input  logic [7:0]   error_fix_en,
  output logic [7:0]   fault_channel_mask,
  output logic [1:0]   fault_state,
  output logic         evt_valid,
  input  logic         evt_ready,
  output logic [31:0]  evt_data,
  output logic         evt_overflow,
  output logic [7:0]   evt_drop_cnt,
  output logic [127:0] fix_count
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0]      CONF_C  = 4'(CONFIRM_CNT);
  localparam logic [7:0]      CLR_C   = 8'(CLEAR_CNT);
  localparam logic [AW:0]     DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_SUSPECT   = 2'd1,
    ST_CONFIRMED = 2'd2,
    ST_RECOVER   = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    EVT_SET    = 4'd1,
    EVT_CHANGE = 4'd2,
    EVT_CLEAR  = 4'd3
  } evt_type_e;

  state_e      state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  clr_q, clr_d;
  logic [23:0] ts_q;

  logic        evt_fire;
  evt_type_e   evt_type;
  logic [3:0]  evt_code;

  logic        pend_vld;
  logic [31:0] pend_data;

  // Confirmed channels: a single bit for a channel fault, all bits for an
  // uncorrectable code.
  function automatic logic [7:0] mask_of(input state_e s, input logic [3:0] c);
    logic [7:0] m;
    m = 8'h00;
    if (s == ST_CONFIRMED || s == ST_RECOVER) begin
      if (c >= 4'd1 && c <= 4'd8) m = 8'h01 << (c - 4'd1);
      else if (c >= 4'd9)         m = 8'hFF;
    end
    return m;
  endfunction

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    clr_d    = clr_q;
    evt_fire = 1'b0;
    evt_type = EVT_SET;
    evt_code = cand_q;
    if (judge_result_smoother_en) begin
      case (state_q)
        ST_NORMAL: begin
          if (judge_result_smoother != 4'd0) begin
            state_d = ST_SUSPECT;
            cand_d  = judge_result_smoother;
            cnt_d   = 4'd1;
          end
        end
        ST_SUSPECT: begin
          if (judge_result_smoother == 4'd0) begin
            state_d = ST_NORMAL;
            cnt_d   = 4'd0;
          end else if (judge_result_smoother == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == CONF_C) begin
              state_d  = ST_CONFIRMED;
              evt_fire = 1'b1;
              evt_type = EVT_SET;
            end
          end else begin
            cand_d = judge_result_smoother;
            cnt_d  = 4'd1;
          end
        end
        ST_CONFIRMED: begin
          if (judge_result_smoother == 4'd0) begin
            state_d = ST_RECOVER;
            clr_d   = 8'd1;
          end else if (judge_result_smoother != cand_q) begin
            cand_d   = judge_result_smoother;
            evt_fire = 1'b1;
            evt_type = EVT_CHANGE;
            evt_code = judge_result_smoother;
          end
        end
        ST_RECOVER: begin
          if (judge_result_smoother == 4'd0) begin
            clr_d = clr_q + 8'd1;
            if (clr_q + 8'd1 == CLR_C) begin
              state_d  = ST_NORMAL;
              clr_d    = 8'd0;
              cnt_d    = 4'd0;
              evt_fire = 1'b1;
              evt_type = EVT_CLEAR;
            end
          end else begin
            state_d = ST_CONFIRMED;
            clr_d   = 8'd0;
            if (judge_result_smoother != cand_q) begin
              cand_d   = judge_result_smoother;
              evt_fire = 1'b1;
              evt_type = EVT_CHANGE;
              evt_code = judge_result_smoother;
            end
          end
        end
        default: state_d = ST_NORMAL;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q            <= ST_NORMAL;
      cand_q             <= 4'd0;
      cnt_q              <= 4'd0;
      clr_q              <= 8'd0;
      ts_q               <= 24'd0;
      fault_channel_mask <= 8'h00;
      pend_vld           <= 1'b0;
      pend_data          <= 32'd0;
    end else begin
      state_q            <= state_d;
      cand_q             <= cand_d;
      cnt_q              <= cnt_d;
      clr_q              <= clr_d;
      ts_q               <= ts_q + 24'd1;
      fault_channel_mask <= mask_of(state_d, cand_d);
      // Event is staged here and pushed into the FIFO on the next edge.
      pend_vld           <= evt_fire;
      pend_data          <= {ts_q, evt_code, evt_type};
    end
  end

  assign fault_state = state_q;

  // Event FIFO
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          full, pop, push_ok, drop;

  assign full    = (count_q == DEPTH_C);
  assign pop     = evt_valid && evt_ready;
  assign push_ok = pend_vld && (!full || pop);
  assign drop    = pend_vld && full && !pop;

  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      evt_overflow <= 1'b0;
      evt_drop_cnt <= 8'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      if (drop) begin
        evt_overflow <= 1'b1;
        if (evt_drop_cnt != 8'hFF) evt_drop_cnt <= evt_drop_cnt + 8'd1;
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers define
  // which entries are live and evt_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (!rstn && push_ok) mem[wr_ptr] <= pend_data;
  end

  assign evt_valid = (count_q != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr] : 32'd0;

`ifdef FT_MON_FIX_CNT_EN
  logic [15:0] fix_q [8];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rstn)                                     fix_q[i] <= 16'd0;
      else if (error_fix_en[i] && fix_q[i] != 16'hFFFF) fix_q[i] <= fix_q[i] + 16'd1;
    end
  end

  always_comb begin
    fix_count = '0;
    for (int i = 0; i < 8; i++) fix_count[16*i +: 16] = fix_q[i];
  end
`else
  logic unused_fix_en;
  assign unused_fix_en = ^error_fix_en;
  assign fix_count     = '0;
`endif

endmodule

// File: tb/tb_ft_fault_monitor.sv
// tb_ft_fault_monitor
//   Directed self-checking bench for ft_fault_monitor (default parameters).
//   Inputs are driven on the falling edge, outputs sampled on the falling edge.
module tb_ft_fault_monitor;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic [3:0]   judge = 4'd0;
  logic         jen = 1'b0;
  logic [7:0]   error_fix = 8'h00;
  logic [7:0]   fault_channel_mask;
  logic [1:0]   fault_state;
  logic         evt_valid;
  logic         evt_ready = 1'b0;
  logic [31:0]  evt_data;
  logic         evt_overflow;
  logic [7:0]   evt_drop_cnt;
  logic [127:0] fix_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] ts_m;
  logic [23:0] last_ts;

  ft_fault_monitor dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .judge_result_smoother    (judge),
    .judge_result_smoother_en (jen),
    .error_fix_en             (error_fix),
    .fault_channel_mask       (fault_channel_mask),
    .fault_state              (fault_state),
    .evt_valid                (evt_valid),
    .evt_ready                (evt_ready),
    .evt_data                 (evt_data),
    .evt_overflow             (evt_overflow),
    .evt_drop_cnt             (evt_drop_cnt),
    .fix_count                (fix_count)
  );

  always #5 clk = ~clk;

  // Reference clock counter for expected timestamps.
  always @(posedge clk) begin
    if (rstn) ts_m <= 24'd0;
    else      ts_m <= ts_m + 24'd1;
  end

  // Reset for two cycles with junk on every input.
  task automatic apply_reset;
    @(negedge clk);
    rstn = 1'b1; jen = 1'b1; judge = 4'd3; error_fix = 8'hFF; evt_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0; jen = 1'b0; judge = 4'd0; error_fix = 8'h00;
  endtask

  // One-cycle code strobe; returns on the falling edge after the sampling edge.
  task automatic strobe(input logic [3:0] code);
    @(negedge clk);
    judge = code; jen = 1'b1; last_ts = ts_m;
    @(negedge clk);
    jen = 1'b0; judge = 4'd0;
  endtask

  // Wait (bounded) for an event and pop it.
  task automatic pop_event(output logic [31:0] d, output bit ok);
    for (int i = 0; i < 8 && !evt_valid; i++) @(negedge clk);
    ok = evt_valid;
    d  = evt_data;
    if (ok) begin
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    apply_reset;
    n_checks++; if (fault_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", fault_state); end
    n_checks++; if (fault_channel_mask !== 8'h00) begin n_fail++; $display("FAIL reset_mask: got %h expected 00", fault_channel_mask); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
    n_checks++; if (evt_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", evt_data); end
    n_checks++; if (evt_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", evt_overflow); end
    n_checks++; if (evt_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", evt_drop_cnt); end
    n_checks++; if (fix_count !== 128'd0) begin n_fail++; $display("FAIL reset_fix: got %h expected 0", fix_count); end
  endtask

  task automatic test_confirm;
    logic [31:0] d; bit ok; logic [23:0] ts_set;
    apply_reset;
    repeat (3) strobe(4'd3);
    n_checks++; if (fault_state !== 2'd1) begin n_fail++; $display("FAIL confirm_suspect: got %0d expected 1", fault_state); end
    strobe(4'd3); ts_set = last_ts;
    n_checks++; if (fault_state !== 2'd2) begin n_fail++; $display("FAIL confirm_state: got %0d expected 2", fault_state); end
    n_checks++; if (fault_channel_mask !== 8'h04) begin n_fail++; $display("FAIL confirm_mask: got %h expected 04", fault_channel_mask); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL confirm_latency_early: got %b expected 0", evt_valid); end
    @(negedge clk);
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL confirm_latency: got %b expected 1", evt_valid); end
    pop_event(d, ok);
    n_checks++; if (!ok || d !== {ts_set, 4'd3, 4'd1}) begin n_fail++; $display("FAIL confirm_event: got %h expected %h", d, {ts_set, 4'd3, 4'd1}); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL confirm_empty: got %b expected 0", evt_valid); end
  endtask

  task automatic test_change_cand;
    logic [31:0] d; bit ok;
    apply_reset;
    strobe(4'd3); strobe(4'd3); strobe(4'd5); strobe(4'd5); strobe(4'd5);
    repeat (2) @(negedge clk);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL cand_no_event: got %b expected 0", evt_valid); end
    n_checks++; if (fault_state !== 2'd1) begin n_fail++; $display("FAIL cand_suspect: got %0d expected 1", fault_state); end
    strobe(4'd5);
    n_checks++; if (fault_state !== 2'd2) begin n_fail++; $display("FAIL cand_state: got %0d expected 2", fault_state); end
    n_checks++; if (fault_channel_mask !== 8'h10) begin n_fail++; $display("FAIL cand_mask: got %h expected 10", fault_channel_mask); end
    pop_event(d, ok);
    n_checks++; if (!ok || d !== {last_ts, 4'd5, 4'd1}) begin n_fail++; $display("FAIL cand_event: got %h expected %h", d, {last_ts, 4'd5, 4'd1}); end
  endtask

  task automatic test_clear;
    logic [31:0] d; bit ok;
    apply_reset;
    repeat (4) strobe(4'd3);
    pop_event(d, ok);
    repeat (15) strobe(4'd0);
    n_checks++; if (fault_state !== 2'd3) begin n_fail++; $display("FAIL clear_recover: got %0d expected 3", fault_state); end
    n_checks++; if (fault_channel_mask !== 8'h04) begin n_fail++; $display("FAIL clear_recover_mask: got %h expected 04", fault_channel_mask); end
    strobe(4'd0);
    n_checks++; if (fault_state !== 2'd0) begin n_fail++; $display("FAIL clear_state: got %0d expected 0", fault_state); end
    n_checks++; if (fault_channel_mask !== 8'h00) begin n_fail++; $display("FAIL clear_mask: got %h expected 00", fault_channel_mask); end
    pop_event(d, ok);
    n_checks++; if (!ok || d !== {last_ts, 4'd3, 4'd3}) begin n_fail++; $display("FAIL clear_event: got %h expected %h", d, {last_ts, 4'd3, 4'd3}); end
    // Recovery interrupted one zero short of the clear threshold.
    repeat (4) strobe(4'd3);
    pop_event(d, ok);
    repeat (15) strobe(4'd0);
    strobe(4'd3);
    n_checks++; if (fault_state !== 2'd2) begin n_fail++; $display("FAIL reconfirm_state: got %0d expected 2", fault_state); end
    repeat (3) @(negedge clk);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reconfirm_no_event: got %b expected 0", evt_valid); end
    n_checks++; if (fault_channel_mask !== 8'h04) begin n_fail++; $display("FAIL reconfirm_mask: got %h expected 04", fault_channel_mask); end
    // Different code while recovering: back to CONFIRMED with a CHANGE.
    strobe(4'd0);
    strobe(4'd5);
    n_checks++; if (fault_state !== 2'd2 || fault_channel_mask !== 8'h10) begin n_fail++; $display("FAIL recover_change: got state %0d mask %h expected 2 10", fault_state, fault_channel_mask); end
    pop_event(d, ok);
    n_checks++; if (!ok || d !== {last_ts, 4'd5, 4'd2}) begin n_fail++; $display("FAIL recover_change_event: got %h expected %h", d, {last_ts, 4'd5, 4'd2}); end
  endtask

  task automatic test_overflow;
    logic [31:0] d; bit ok;
    logic [23:0] ts_arr [10];
    logic [3:0]  code_arr [10];
    logic [3:0]  c;
    apply_reset;
    repeat (4) strobe(4'd2);
    n_checks++; if (fault_channel_mask !== 8'h02) begin n_fail++; $display("FAIL ovf_mask2: got %h expected 02", fault_channel_mask); end
    pop_event(d, ok);
    for (int i = 0; i < 10; i++) begin
      c = (i % 2 == 0) ? 4'd9 : 4'd2;
      strobe(c);
      ts_arr[i] = last_ts; code_arr[i] = c;
      if (i == 0) begin
        n_checks++; if (fault_channel_mask !== 8'hFF) begin n_fail++; $display("FAIL ovf_mask_ff: got %h expected ff", fault_channel_mask); end
      end
    end
    repeat (2) @(negedge clk);
    n_checks++; if (evt_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", evt_overflow); end
    n_checks++; if (evt_drop_cnt !== 8'd2) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d expected 2", evt_drop_cnt); end
    for (int i = 0; i < 8; i++) begin
      pop_event(d, ok);
      n_checks++; if (!ok || d !== {ts_arr[i], code_arr[i], 4'd2}) begin n_fail++; $display("FAIL ovf_entry%0d: got %h expected %h", i, d, {ts_arr[i], code_arr[i], 4'd2}); end
    end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b expected 0", evt_valid); end
    // Refill to full, then push with a simultaneous pop.
    for (int i = 0; i < 8; i++) strobe((i % 2 == 0) ? 4'd9 : 4'd2);
    repeat (2) @(negedge clk);
    strobe(4'd9);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (evt_drop_cnt !== 8'd2) begin n_fail++; $display("FAIL full_push_pop_drop: got %0d expected 2", evt_drop_cnt); end
    for (int i = 0; i < 8; i++) pop_event(d, ok);
    n_checks++; if (!ok || d[7:0] !== {4'd9, 4'd2}) begin n_fail++; $display("FAIL full_push_pop_last: got %h expected 92", d[7:0]); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL full_push_pop_empty: got %b expected 0", evt_valid); end
  endtask

  task automatic test_reset_mid;
    // Continues from test_overflow: confirmed with cand 9, overflow sticky set.
    strobe(4'd2); strobe(4'd9); strobe(4'd2);
    repeat (2) @(negedge clk);
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL mid_queued: got %b expected 1", evt_valid); end
    rstn = 1'b1; jen = 1'b1; judge = 4'd5; error_fix = 8'hFF;
    @(negedge clk);
    n_checks++; if (evt_valid !== 1'b0 || evt_data !== 32'd0) begin n_fail++; $display("FAIL mid_evt: got valid %b data %h expected 0 0", evt_valid, evt_data); end
    n_checks++; if (fault_state !== 2'd0 || fault_channel_mask !== 8'h00) begin n_fail++; $display("FAIL mid_state: got %0d mask %h expected 0 00", fault_state, fault_channel_mask); end
    n_checks++; if (evt_overflow !== 1'b0 || evt_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_ovf: got %b %0d expected 0 0", evt_overflow, evt_drop_cnt); end
    n_checks++; if (fix_count !== 128'd0) begin n_fail++; $display("FAIL mid_fix: got %h expected 0", fix_count); end
    rstn = 1'b0; jen = 1'b0; judge = 4'd0; error_fix = 8'h00;
    @(negedge clk);
    n_checks++; if (fault_state !== 2'd0 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_inputs_ignored: got %0d %b expected 0 0", fault_state, evt_valid); end
  endtask

  task automatic test_fix_count;
    apply_reset;
`ifdef FT_MON_FIX_CNT_EN
    @(negedge clk);
    error_fix = 8'h82;
    repeat (5) @(negedge clk);
    error_fix = 8'h00;
    n_checks++; if (fix_count[31:16] !== 16'd5 || fix_count[127:112] !== 16'd5 || fix_count[15:0] !== 16'd0) begin n_fail++; $display("FAIL fix_lanes: got %h expected lanes 1,7 = 5", fix_count); end
    apply_reset;
    error_fix = 8'h01;
    repeat (70000) @(negedge clk);
    error_fix = 8'h00;
    @(negedge clk);
    n_checks++; if (fix_count[15:0] !== 16'hFFFF) begin n_fail++; $display("FAIL fix_saturate: got %h expected ffff", fix_count[15:0]); end
    n_checks++; if (fix_count[127:16] !== 112'd0) begin n_fail++; $display("FAIL fix_other_lanes: got %h expected 0", fix_count[127:16]); end
`else
    error_fix = 8'hFF;
    repeat (20) @(negedge clk);
    error_fix = 8'h00;
    n_checks++; if (fix_count !== 128'd0) begin n_fail++; $display("FAIL fix_disabled: got %h expected 0", fix_count); end
`endif
  endtask

  initial begin
    test_reset;
    test_confirm;
    test_change_cand;
    test_clear;
    test_overflow;
    test_reset_mid;
    test_fix_count;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ft_fault_monitor.md
FT_FAULT_MONITOR -- requirements
Module: ft_fault_monitor

Interface
REQ-001 SHALL have parameter CONFIRM_CNT, default 4, consecutive matching fault codes needed to confirm a fault (range 2..15).
REQ-002 SHALL have parameter CLEAR_CNT, default 16, consecutive zero codes needed to clear a confirmed fault (range 2..255).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of 2, 2..64).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rstn  in  1  synchronous, active-high reset.
REQ-006 SHALL have port judge_result_smoother  in  4  fault code: 0 = none; 1..8 = channel 0..7 faulty; 9..15 = uncorrectable.
REQ-007 SHALL have port judge_result_smoother_en  in  1  code valid strobe.
REQ-008 SHALL have port error_fix_en  in  8  per-channel corrected-sample strobe.
REQ-009 SHALL have port fault_channel_mask  out  8  confirmed faulty channels.
REQ-010 SHALL have port fault_state  out  2  0 NORMAL, 1 SUSPECT, 2 CONFIRMED, 3 RECOVER.
REQ-011 SHALL have port evt_valid  out  1  event available.
REQ-012 SHALL have port evt_ready  in  1  consumer accepts event.
REQ-013 SHALL have port evt_data  out  32  {timestamp[23:0], code[3:0], type[3:0]}; type 1 SET, 2 CHANGE, 3 CLEAR.
REQ-014 SHALL have port evt_overflow  out  1  sticky: an event was dropped.
REQ-015 SHALL have port evt_drop_cnt  out  8  dropped events, saturating at 255.
REQ-016 SHALL have port fix_count  out  128  eight 16-bit per-channel fix counters, channel 0 in [15:0].

Function
REQ-017 SHALL update the state machine only in cycles with judge_result_smoother_en=1; other cycles hold state and counters.
REQ-018 NORMAL: nonzero code -> SUSPECT, cand=code, cnt=1.
REQ-019 SUSPECT: code==cand -> cnt+1, reaching CONFIRM_CNT -> CONFIRMED plus SET event; different nonzero code -> cand=code, cnt=1; zero -> NORMAL, no event.
REQ-020 CONFIRMED: zero -> RECOVER, clr=1; different nonzero code -> CHANGE event, cand=code, stay; code==cand -> stay.
REQ-021 RECOVER: zero -> clr+1, reaching CLEAR_CNT -> NORMAL plus CLEAR event (code field = cand); code==cand -> CONFIRMED, clr=0, no event; different nonzero -> CONFIRMED, cand=code, CHANGE event.
REQ-022 fault_channel_mask SHALL be registered: in CONFIRMED/RECOVER, bit cand-1 for cand 1..8, 8'hFF for cand 9..15; else 0; updates the cycle after the transition.
REQ-023 timestamp SHALL be a free-running 24-bit clock counter wrapping 0xFFFFFF->0, sampled in the triggering cycle.
REQ-024 Event SHALL be written to FIFO in the cycle after the triggering strobe and evt_valid SHALL assert one cycle after that write (2-cycle latency, FIFO read data registered/first-word fall-through).
REQ-025 An event SHALL pop when evt_valid && evt_ready; evt_data SHALL be stable while evt_valid && !evt_ready.
REQ-026 Push when full and no pop SHALL drop the event, set evt_overflow, increment evt_drop_cnt; push with simultaneous pop when full SHALL be accepted.
REQ-027 Empty FIFO SHALL hold evt_valid=0; pop on empty is ignored.

Reset
REQ-028 rstn=1 at a clock edge SHALL clear: state NORMAL, cand, cnt, clr, timestamp, FIFO pointers, fault_channel_mask=0, fault_state=0, evt_valid=0, evt_data=0, evt_overflow=0, evt_drop_cnt=0, fix_count=0; reset mid-operation discards pending events.
REQ-029 Inputs SHALL be ignored during the reset cycle.

Configuration
REQ-030 Macro FT_MON_FIX_CNT_EN defined: each fix_count lane increments on its error_fix_en bit, saturating at 0xFFFF.
REQ-031 Macro FT_MON_FIX_CNT_EN undefined: no counter logic; fix_count tied to 0.

Verification
REQ-032 4 strobes of code 3 from reset -> fault_state=2, mask=8'h04, one event type 1 code 3.
REQ-033 Codes 3,3,5,5,5,5 -> no event until 4th 5, then SET code 5; mask=8'h10.
REQ-034 Confirmed code 3, then 16 zero strobes -> CLEAR event code 3, mask=0, state 0; 15 zeros then 3 -> back to CONFIRMED, no event.
REQ-035 Confirmed, evt_ready=0, alternate codes 9/2 generating 10 CHANGE events -> 8 stored, evt_overflow=1, evt_drop_cnt=2; mask 8'hFF while cand=9.
REQ-036 Reset asserted with 3 events queued -> evt_valid=0 next cycle, all outputs zero.
REQ-037 With FT_MON_FIX_CNT_EN, error_fix_en=8'h01 for 70000 cycles -> fix_count[15:0]=0xFFFF, other lanes 0; without macro fix_count=0.
